// File: rtl/multi_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : multi_seq_detector
//  Description : N-channel serial pattern detector. Each channel compares its
//                serial input against a pattern of 1..PAT_MAX bits that is
//                programmed at runtime. Overlap or non-overlap matching is
//                selectable per channel. Each channel has a one-cycle match
//                pulse and a saturating match counter.
//  Ports       :
//    clk          in   system clock, rising edge
//    reset        in   asynchronous active-low reset
//    sample_en    in   qualifies din; a bit is consumed only when high
//    din          in   [NCH]       serial data, bit i = channel i
//    cfg_we       in   configuration write strobe
//    cfg_ch       in   [CH_W]      channel being configured
//    cfg_pattern  in   [PAT_MAX]   pattern, bit len-1 = first bit received
//    cfg_len      in   [LEN_W]     pattern length, 0 = channel disabled
//    cfg_overlap  in   1 = overlapping matches, 0 = non-overlapping
//    cnt_clr      in   synchronous clear of all match counters
//    match        out  [NCH]       registered one-cycle match pulse
//    match_any    out  OR of match
//    match_cnt    out  [NCH*CNT_W] saturating counters, ch i at [i*CNT_W +: CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_seq_detector #(
  parameter int NCH     = 3,
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int CH_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic [NCH-1:0]         din,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [PAT_MAX-1:0]     cfg_pattern,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   cfg_overlap,
  input  logic                   cnt_clr,
  output logic [NCH-1:0]         match,
  output logic                   match_any,
  output logic [NCH*CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    // The oldest history bit is shifted out before any compare could use it,
    // so only PAT_MAX-1 bits are stored; the full post-shift history is
    // rebuilt as {hist_q, din}.
    logic [PAT_MAX-2:0] hist_q, hist_d;
    logic [PAT_MAX-1:0] hist_sh;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic               cfg_sel;
    logic               ch_en;
    logic               hit;

    // Out-of-range channel numbers never equal any gi, so such writes drop.
    assign cfg_sel  = cfg_we && (cfg_ch == CH_W'(gi));
    assign len_eff  = (len_q > LEN_MAX) ? LEN_MAX : len_q;
    assign ch_en    = (len_eff != '0);
    assign hist_sh  = {hist_q, din[gi]};
    assign fill_inc = (fill_q >= len_eff) ? len_eff : fill_q + LEN_W'(1);

    // Low len_eff bits set: selects the part of history/pattern compared.
    always_comb begin
      mask = '0;
      for (int b = 0; b < PAT_MAX; b++) begin
        if (b < int'(len_eff)) begin
          mask[b] = 1'b1;
        end
      end
    end

    assign hit = ch_en && (fill_inc >= len_eff) &&
                 ((hist_sh & mask) == (pat_q & mask));

    always_comb begin
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      if (cfg_sel) begin
        // A sample coinciding with a config write is discarded.
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end else if (sample_en && ch_en) begin
        hist_d  = hist_sh[PAT_MAX-2:0];
        match_d = hit;
        // Non-overlap: restart the fill count so the next match needs len
        // fresh bits.
        fill_d  = (hit && !ovl_q) ? '0 : fill_inc;
      end
    end

    // Clear takes priority over a coincident match pulse.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
        cnt_d = '0;
      end else if (match_q && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pat_q   <= '0;
        len_q   <= '0;
        ovl_q   <= 1'b0;
        hist_q  <= '0;
        fill_q  <= '0;
        match_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        pat_q   <= pat_d;
        len_q   <= len_d;
        ovl_q   <= ovl_d;
        hist_q  <= hist_d;
        fill_q  <= fill_d;
        match_q <= match_d;
        cnt_q   <= cnt_d;
      end
    end

    assign match[gi]                    = match_q;
    assign match_cnt[gi*CNT_W +: CNT_W] = cnt_q;
  end

  assign match_any = |match;

endmodule
`default_nettype wire

// File: tb/tb_multi_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_seq_detector
//  Description : Directed self-checking bench for multi_seq_detector. A
//                default instance and a CNT_W=2 instance share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_seq_detector;

  localparam int NCH = 3;

  logic           clk;
  logic           reset;
  logic           sample_en;
  logic [NCH-1:0] din;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_pattern;
  logic [3:0]     cfg_len;
  logic           cfg_overlap;
  logic           cnt_clr;
  logic [NCH-1:0] match;
  logic           match_any;
  logic [23:0]    match_cnt;
  logic [NCH-1:0] match_s;
  logic           match_any_s;
  logic [5:0]     match_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  multi_seq_detector u_dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .din(din),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .match(match), .match_any(match_any), .match_cnt(match_cnt)
  );

  multi_seq_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .sample_en(sample_en), .din(din),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .match(match_s), .match_any(match_any_s), .match_cnt(match_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic program_ch(input int ch, input logic [7:0] pat, input logic [3:0] len,
                            input logic ovl);
    cfg_we      = 1'b1;
    cfg_ch      = 2'(ch);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    tick();
    cfg_we      = 1'b0;
  endtask

  // Sample one bit on channel ch (others see 0) and check the pulse after it.
  task automatic send_chk(input int ch, input logic b, input logic exp, input string tag);
    din       = '0;
    din[ch]   = b;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    din       = '0;
    check(tag, 32'(match[ch]), 32'(exp));
    check({tag, "_any"}, 32'(match_any), 32'(exp));
  endtask

  initial begin
    logic [NCH-1:0] seen;
    logic           seen_any;
    logic [6:0]     bits7;
    logic [6:0]     exp7;
    logic [3:0]     bits4;
    logic [3:0]     exp4;
    logic [7:0]     bits8;

    reset = 1'b0; sample_en = 1'b0; din = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_match", 32'(match), 0);
    check("rst_any", 32'(match_any), 0);
    check("rst_cnt", 32'(match_cnt), 0);
    check("rst_cnt_sat", 32'(match_cnt_s), 0);

    // All channels disabled: random traffic must never match.
    seen = '0; seen_any = 1'b0;
    for (int k = 0; k < 16; k++) begin
      din = 3'($urandom_range(0, 7));
      sample_en = 1'b1;
      tick();
      seen |= match | match_s;
      seen_any |= match_any | match_any_s;
    end
    sample_en = 1'b0; din = '0;
    tick();
    check("dis_match", 32'(seen), 0);
    check("dis_any", 32'(seen_any), 0);
    check("dis_cnt", 32'(match_cnt), 0);

    // ch0: 1011 overlapping, stream 1011011.
    program_ch(0, 8'b1011, 4'd4, 1'b1);
    bits7 = 7'b1011011;
    exp7  = 7'b0001001;
    for (int k = 0; k < 7; k++) begin
      send_chk(0, bits7[6-k], exp7[6-k], $sformatf("ch0_b%0d", k));
    end
    tick();
    check("ch0_idle", 32'(match[0]), 0);
    check("ch0_cnt", 32'(match_cnt[7:0]), 2);
    check("ch0_cnt_sat", 32'(match_cnt_s[1:0]), 2);

    // ch1: 11 overlapping then non-overlapping.
    program_ch(1, 8'b11, 4'd2, 1'b1);
    exp4 = 4'b0111;
    for (int k = 0; k < 4; k++) send_chk(1, 1'b1, exp4[3-k], $sformatf("ch1_ov_b%0d", k));
    program_ch(1, 8'b11, 4'd2, 1'b0);
    exp4 = 4'b0101;
    for (int k = 0; k < 4; k++) send_chk(1, 1'b1, exp4[3-k], $sformatf("ch1_no_b%0d", k));
    tick();
    check("ch1_cnt", 32'(match_cnt[15:8]), 5);

    // Sample coincident with a config write is discarded.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1;
    sample_en = 1'b1; din = 3'b010;
    tick();
    cfg_we = 1'b0; sample_en = 1'b0; din = '0;
    send_chk(1, 1'b1, 1'b0, "ch1_disc_b0");
    send_chk(1, 1'b1, 1'b1, "ch1_disc_b1");
    tick();
    check("ch1_cnt2", 32'(match_cnt[15:8]), 6);

    // ch2: 101 with a 3-cycle stall between the 0 and the final 1.
    program_ch(2, 8'b101, 4'd3, 1'b0);
    send_chk(2, 1'b1, 1'b0, "ch2_b0");
    send_chk(2, 1'b0, 1'b0, "ch2_b1");
    din = 3'b100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ch2_stall%0d", k), 32'(match[2]), 0);
    end
    din = '0;
    send_chk(2, 1'b1, 1'b1, "ch2_b2");

    // Write to a nonexistent channel must not disturb ch2.
    program_ch(3, 8'h01, 4'd1, 1'b1);
    send_chk(2, 1'b1, 1'b0, "bad_ch");

    // Length above PAT_MAX is clamped to 8.
    program_ch(2, 8'hA5, 4'd15, 1'b0);
    bits8 = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      send_chk(2, bits8[7-k], (k == 7), $sformatf("ch2_len15_b%0d", k));
    end

    // Counter saturation on the CNT_W=2 instance.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", 32'(match_cnt), 0);
    check("clr_cnt_sat", 32'(match_cnt_s), 0);
    program_ch(0, 8'b11, 4'd2, 1'b1);
    for (int k = 0; k < 6; k++) send_chk(0, 1'b1, (k != 0), $sformatf("sat_b%0d", k));
    tick();
    check("sat_cnt_full", 32'(match_cnt[7:0]), 5);
    check("sat_cnt_sat", 32'(match_cnt_s[1:0]), 3);
    send_chk(0, 1'b1, 1'b1, "clr_hit");
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_win", 32'(match_cnt[7:0]), 0);
    check("clr_win_sat", 32'(match_cnt_s[1:0]), 0);
    tick();
    check("clr_win2", 32'(match_cnt[7:0]), 0);

    // Asynchronous reset in the middle of a stream.
    program_ch(0, 8'b1011, 4'd4, 1'b1);
    bits7 = 7'b1011011;
    exp7  = 7'b0001001;
    for (int k = 0; k < 7; k++) begin
      send_chk(0, bits7[6-k], exp7[6-k], $sformatf("mid_b%0d", k));
    end
    check("mid_cnt_pre", 32'(match_cnt[7:0]), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_match", 32'(match), 0);
    check("arst_any", 32'(match_any), 0);
    check("arst_cnt", 32'(match_cnt), 0);
    check("arst_cnt_sat", 32'(match_cnt_s), 0);
    #2 reset = 1'b1;
    bits4 = 4'b1011;
    for (int k = 0; k < 4; k++) send_chk(0, bits4[3-k], 1'b0, $sformatf("post_b%0d", k));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
